// File: rtl/alto_memory_arbiter.sv
// Two-master round-robin Wishbone arbiter (CPU = m0, DMA = m1) in front of one 16-bit memory port.
// Optional hung-slave abort is compiled in with `define ALTO_MEMORY_ARBITER_TIMEOUT_EN.
module alto_memory_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int TWIDTH  = 7
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [16:1] m0_adr_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    input  logic        m0_we_i,
    input  logic [1:0]  m0_sel_i,
    input  logic [15:0] m0_dat_i,
    output logic [15:0] m0_dat_o,
    output logic        m0_ack_o,
    input  logic [16:1] m1_adr_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    input  logic        m1_we_i,
    input  logic [1:0]  m1_sel_i,
    input  logic [15:0] m1_dat_i,
    output logic [15:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic [16:1] s_adr_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    output logic        s_we_o,
    output logic [1:0]  s_sel_o,
    output logic [15:0] s_dat_o,
    input  logic [15:0] s_dat_i,
    input  logic        s_ack_i,
    output logic [1:0]  grant_o,
    output logic        err_o
);

    // State encoding doubles as the one-hot grant vector {m1,m0}.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t state;
    logic   last;
    logic   cur_stb;
    logic   cur_cyc;
    logic   abort;

    if (2 ** TWIDTH <= TIMEOUT) begin : g_bad_twidth
        $error("alto_memory_arbiter: TWIDTH too small for TIMEOUT");
    end

    always_comb begin
        cur_stb = 1'b0;
        cur_cyc = 1'b0;
        case (state)
            GNT0: begin
                cur_stb = m0_stb_i;
                cur_cyc = m0_cyc_i;
            end
            GNT1: begin
                cur_stb = m1_stb_i;
                cur_cyc = m1_cyc_i;
            end
            default: ;
        endcase
    end

`ifdef ALTO_MEMORY_ARBITER_TIMEOUT_EN
    logic [TWIDTH-1:0] cnt;

    // Abort fires on the TIMEOUT-th consecutive unacknowledged strobe cycle.
    assign abort = ~rst_i & cur_stb & ~s_ack_i & (cnt == TWIDTH'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || s_ack_i || abort || state == IDLE || !cur_cyc) begin
            cnt <= '0;
        end else if (cur_stb) begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign abort = 1'b0;
`endif

    assign err_o   = abort;
    assign grant_o = state;

    always_comb begin
        s_adr_o  = '0;
        s_stb_o  = 1'b0;
        s_cyc_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_dat_o = 16'hFFFF;
        m1_dat_o = 16'hFFFF;
        case (state)
            GNT0: begin
                s_adr_o  = m0_adr_i;
                s_stb_o  = m0_stb_i & ~abort;
                s_cyc_o  = m0_cyc_i & ~abort;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = (s_ack_i & ~rst_i) | abort;
                m0_dat_o = abort ? 16'hFFFF : s_dat_i;
            end
            GNT1: begin
                s_adr_o  = m1_adr_i;
                s_stb_o  = m1_stb_i & ~abort;
                s_cyc_o  = m1_cyc_i & ~abort;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = (s_ack_i & ~rst_i) | abort;
                m1_dat_o = abort ? 16'hFFFF : s_dat_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    // On a tie, the master that was not served last wins.
                    if (m0_cyc_i && (!m1_cyc_i || last)) begin
                        state <= GNT0;
                    end else if (m1_cyc_i) begin
                        state <= GNT1;
                    end
                end
                GNT0: begin
                    if (abort) begin
                        last  <= 1'b0;
                        state <= IDLE;
                    end else if (!m0_cyc_i) begin
                        last  <= 1'b0;
                        state <= m1_cyc_i ? GNT1 : IDLE;
                    end
                end
                GNT1: begin
                    if (abort) begin
                        last  <= 1'b1;
                        state <= IDLE;
                    end else if (!m1_cyc_i) begin
                        last  <= 1'b1;
                        state <= m0_cyc_i ? GNT0 : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
